// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered read data, occupancy flags and sticky error flags
module fifo_sync_param #(
   parameter int MEMORY_WIDTH = 8,
   parameter int MEMORY_DEPTH = 16,
   parameter int AF_LEVEL     = MEMORY_DEPTH - 2,
   parameter int AE_LEVEL     = 2,
   localparam int ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
   localparam int COUNT_SIZE   = $clog2(MEMORY_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    w_en,
   input  logic                    r_en,
   input  logic [MEMORY_WIDTH-1:0] WR,
   input  logic                    clr_err,
   output logic [MEMORY_WIDTH-1:0] RD,
   output logic                    RD_VALID,
   output logic                    FULL,
   output logic                    EMPTY,
   output logic                    ALMOST_FULL,
   output logic                    ALMOST_EMPTY,
   output logic [COUNT_SIZE-1:0]   COUNT,
   output logic                    OVERFLOW,
   output logic                    UNDERFLOW
);
   localparam logic [ADDRESS_SIZE-1:0] A_LAST = ADDRESS_SIZE'(MEMORY_DEPTH - 1);
   localparam logic [ADDRESS_SIZE-1:0] A_ONE  = 1;
   localparam logic [COUNT_SIZE-1:0]   C_ONE  = 1;
   localparam logic [COUNT_SIZE-1:0]   C_FULL = COUNT_SIZE'(MEMORY_DEPTH);
   localparam logic [COUNT_SIZE-1:0]   C_AF   = COUNT_SIZE'(AF_LEVEL);
   localparam logic [COUNT_SIZE-1:0]   C_AE   = COUNT_SIZE'(AE_LEVEL);

   logic [MEMORY_WIDTH-1:0] r_mem [MEMORY_DEPTH];
   logic [ADDRESS_SIZE-1:0] r_wptr, r_rptr;
   logic [COUNT_SIZE-1:0]   r_count;
   logic [MEMORY_WIDTH-1:0] r_rd;
   logic                    r_rd_valid, r_ovf, r_unf;
   logic                    w_rd_acc, w_wr_acc;
   logic [COUNT_SIZE-1:0]   w_count_nxt;

   // acceptance, next occupancy and flag decode from the registered count
   always_comb begin
      w_rd_acc     = r_en & ~EMPTY;
      w_wr_acc     = w_en & (~FULL | w_rd_acc);
      w_count_nxt  = (w_wr_acc & ~w_rd_acc) ? r_count + C_ONE :
                     (w_rd_acc & ~w_wr_acc) ? r_count - C_ONE : r_count;
      FULL         = r_count == C_FULL;
      EMPTY        = r_count == '0;
      ALMOST_FULL  = r_count >= C_AF;
      ALMOST_EMPTY = r_count <= C_AE;
   end

   // storage array, written only on accepted writes and never reset
   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) r_mem[r_wptr] <= WR;
   end

   // pointers, occupancy, read data and sticky errors; set events win over clr_err
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_rd       <= '0;
         r_rd_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= (r_wptr == A_LAST) ? '0 : r_wptr + A_ONE;
         if (w_rd_acc) r_rptr <= (r_rptr == A_LAST) ? '0 : r_rptr + A_ONE;
         if (w_rd_acc) r_rd <= r_mem[r_rptr];
         r_count    <= w_count_nxt;
         r_rd_valid <= w_rd_acc;
         r_ovf      <= (w_en & ~w_wr_acc) ? 1'b1 : clr_err ? 1'b0 : r_ovf;
         r_unf      <= (r_en & EMPTY) ? 1'b1 : clr_err ? 1'b0 : r_unf;
      end
   end

   assign RD        = r_rd;
   assign RD_VALID  = r_rd_valid;
   assign COUNT     = r_count;
   assign OVERFLOW  = r_ovf;
   assign UNDERFLOW = r_unf;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and random checks of fifo_sync_param against a queue-based reference
module tb_fifo_sync_param;
   localparam int W = 8, D = 5, AF = 4, AE = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0, w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
   logic [7:0] WR = '0;
   logic [7:0] RD;
   logic       RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
   logic [2:0] COUNT;

   int n_chk = 0, n_fail = 0;

   logic [7:0] q[$];
   logic [7:0] m_rd;
   logic       m_valid, m_ovf, m_unf;

   fifo_sync_param #(.MEMORY_WIDTH(W), .MEMORY_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .WR(WR), .clr_err(clr_err),
      .RD(RD), .RD_VALID(RD_VALID), .FULL(FULL), .EMPTY(EMPTY),
      .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("COUNT", 32'(COUNT), 32'(q.size()));
      chk("FULL", 32'(FULL), 32'(q.size() == D));
      chk("EMPTY", 32'(EMPTY), 32'(q.size() == 0));
      chk("ALMOST_FULL", 32'(ALMOST_FULL), 32'(q.size() >= AF));
      chk("ALMOST_EMPTY", 32'(ALMOST_EMPTY), 32'(q.size() <= AE));
      chk("RD", 32'(RD), 32'(m_rd));
      chk("RD_VALID", 32'(RD_VALID), 32'(m_valid));
      chk("OVERFLOW", 32'(OVERFLOW), 32'(m_ovf));
      chk("UNDERFLOW", 32'(UNDERFLOW), 32'(m_unf));
   endtask

   task automatic step(input logic s_rst, input logic w, input logic r, input logic [7:0] d, input logic c);
      bit rd_acc, wr_acc;
      rst = s_rst; w_en = w; r_en = r; WR = d; clr_err = c;
      rd_acc = r && q.size() > 0;
      wr_acc = w && (q.size() < D || rd_acc);
      @(posedge clk);
      #1;
      if (s_rst) begin
         q.delete();
         m_rd = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         m_ovf = (w && !wr_acc) ? 1'b1 : c ? 1'b0 : m_ovf;
         m_unf = (r && q.size() == 0) ? 1'b1 : c ? 1'b0 : m_unf;
         m_valid = rd_acc;
         if (rd_acc) m_rd = q.pop_front();
         if (wr_acc) q.push_back(d);
      end
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
      check_all();
   endtask

   initial begin
      m_rd = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      step(1, 0, 0, 8'h00, 0);
      step(1, 1, 1, 8'h55, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h11 + 8'(i), 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h21 + 8'(i), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h31 + 8'(i), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h41 + 8'(i), 0);
      step(0, 1, 1, 8'h99, 0);
      step(0, 1, 0, 8'h77, 0);
      step(0, 1, 0, 8'h78, 1);
      step(0, 0, 0, 8'h00, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00, 0);
      step(0, 1, 1, 8'hAA, 0);
      step(0, 0, 1, 8'h00, 0);
      step(0, 0, 0, 8'h00, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h51 + 8'(i), 0);
      step(1, 0, 1, 8'h00, 0);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 1'($urandom_range(0, 9) == 0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter MEMORY_WIDTH, default 8, SHALL set the data word width in bits (>=1).
REQ-002 Parameter MEMORY_DEPTH, default 16, SHALL set the number of stored words; any value >=2, power of two not required.
REQ-003 Parameter AF_LEVEL, default MEMORY_DEPTH-2, SHALL set the almost-full threshold (1..MEMORY_DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, SHALL set the almost-empty threshold (0..MEMORY_DEPTH-1).
REQ-005 Derived: ADDRESS_SIZE = clog2(MEMORY_DEPTH); COUNT_SIZE = clog2(MEMORY_DEPTH+1).
REQ-006 The design SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-007 Ports SHALL be:
  clk           input   1             rising-edge clock
  rst           input   1             synchronous active-high reset
  w_en          input   1             write request
  r_en          input   1             read request
  WR            input   MEMORY_WIDTH  write data
  clr_err       input   1             clear sticky error flags
  RD            output  MEMORY_WIDTH  registered read data
  RD_VALID      output  1             RD updated this cycle
  FULL          output  1             COUNT == MEMORY_DEPTH
  EMPTY         output  1             COUNT == 0
  ALMOST_FULL   output  1             COUNT >= AF_LEVEL
  ALMOST_EMPTY  output  1             COUNT <= AE_LEVEL
  COUNT         output  COUNT_SIZE    current occupancy
  OVERFLOW      output  1             sticky: write rejected
  UNDERFLOW     output  1             sticky: read rejected

Function
REQ-008 Accepted read (rd_acc) SHALL be r_en & !EMPTY.
REQ-009 Accepted write (wr_acc) SHALL be w_en & (!FULL | rd_acc): a write when full is accepted only alongside an accepted read.
REQ-010 On wr_acc, WR SHALL be stored at w_ptr and w_ptr advance; w_ptr SHALL wrap from MEMORY_DEPTH-1 to 0.
REQ-011 On rd_acc, memory[r_ptr] SHALL load into RD at that clock edge and r_ptr advance with the same wrap rule; RD valid one cycle after the request, RD_VALID high for exactly that cycle.
REQ-012 Without rd_acc, RD SHALL hold its last value and RD_VALID SHALL be 0.
REQ-013 COUNT SHALL be registered: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; it never exceeds MEMORY_DEPTH or drops below 0.
REQ-014 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY SHALL decode combinationally from registered COUNT only (no input-to-flag paths).
REQ-015 Read when EMPTY SHALL be rejected even with simultaneous w_en (no bypass); the write is still accepted.
REQ-016 Simultaneous accepted read and write at equal pointers (full case) SHALL return the old word on RD and store the new word.
REQ-017 OVERFLOW SHALL set on the edge after w_en & !wr_acc; UNDERFLOW SHALL set on the edge after r_en & EMPTY.
REQ-018 clr_err SHALL clear both flags at the next edge; a same-cycle set event SHALL win over clr_err.
REQ-019 Rejected operations SHALL not change pointers, COUNT, memory or RD.

Reset
REQ-020 With rst high at a clock edge: w_ptr, r_ptr, COUNT = 0; RD = 0; RD_VALID, OVERFLOW, UNDERFLOW = 0; hence EMPTY = 1, FULL = 0.
REQ-021 rst SHALL take priority over w_en, r_en and clr_err, including mid-transfer; memory contents are not reset.
REQ-022 Before the first clock edge with rst high, outputs are undefined.

Verification (MEMORY_WIDTH=8, MEMORY_DEPTH=5, AF_LEVEL=4, AE_LEVEL=1 unless stated)
REQ-023 Fill then drain: write 0x11..0x15 -> FULL=1, COUNT=5, ALMOST_FULL from COUNT=4; 5 reads -> RD 0x11..0x15 one cycle after each r_en, RD_VALID each, EMPTY=1.
REQ-024 Wrap (depth 5, non-power-of-2): 3 writes, 3 reads, 4 writes, 4 reads -> data order preserved, pointers wrap 4->0, COUNT ends 0.
REQ-025 Full plus simultaneous w_en/r_en -> oldest word on RD, new word stored, COUNT stays 5, OVERFLOW stays 0; w_en alone when full -> OVERFLOW=1 next cycle, COUNT=5.
REQ-026 r_en on empty with w_en=1, WR=0xAA -> UNDERFLOW=1, RD_VALID=0, COUNT=1; next read returns 0xAA.
REQ-027 clr_err with new overflow same cycle -> OVERFLOW stays 1; clr_err alone -> both flags 0 next cycle.
REQ-028 rst asserted with COUNT=3 and r_en=1 -> next cycle COUNT=0, EMPTY=1, RD=0x00, RD_VALID=0.
